// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared arbiter types, state encoding and one-hot check
package arb_pkg;

    // Default requester count shared by the arbiter, the grant holder and the bench
    localparam int ARB_N = 4;

    // Widest grant vector the one-hot helper accepts
    localparam int ARB_MAX_N = 32;

    localparam logic [ARB_MAX_N-1:0] ARB_ONE = {{(ARB_MAX_N-1){1'b0}}, 1'b1};

    // Ownership life cycle of the grant holder
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

    // True when exactly one bit of v is set
    function automatic logic is_onehot(input logic [ARB_MAX_N-1:0] v);
        return (v != '0) && ((v & (v - ARB_ONE)) == '0);
    endfunction

endpackage

// File: rtl/grant_watchdog.sv
// rtl/grant_watchdog.sv - idle-cycle watchdog for a held grant (GRANT_TIMEOUT_EN builds only)
`ifdef GRANT_TIMEOUT_EN
module grant_watchdog #(
    parameter int TIMEOUT = 16,
    localparam int W = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic active_i,
    input  logic xfer_i,
    output logic expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Count idle cycles while ownership is held; any beat or leaving GRANT restarts the count
    always_comb begin
        cnt_d = cnt_q;
        if (!active_i || xfer_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Idle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The TIMEOUT-th consecutive idle cycle in GRANT is the one that releases
    assign expire_o = active_i && !xfer_i && (cnt_q == W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/grant_hold_ctrl.sv
// rtl/grant_hold_ctrl.sv - latches a one-hot arbiter grant and holds it for a burst; optional watchdog via GRANT_TIMEOUT_EN
module grant_hold_ctrl
    import arb_pkg::*;
#(
    parameter int N         = ARB_N,
    parameter int MAX_BEATS = 8,
    parameter int TIMEOUT   = 16,
    localparam int BW       = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic [N-1:0]  arb_grant,
    input  logic          xfer,
    input  logic          last,
    output logic [N-1:0]  grant,
    output logic          busy,
    output logic [BW-1:0] beat_cnt,
    output logic          done,
    output logic          forced,
    output logic          err_onehot
);

    // Reject configurations the beat counter and watchdog cannot represent
    if (MAX_BEATS < 1 || TIMEOUT < 1 || N > ARB_MAX_N) begin : g_bad_cfg
        $error("grant_hold_ctrl: unsupported parameter set");
    end

    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BEATS - 1);

    arb_state_t      state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic            done_q, done_d;
    logic            forced_q, forced_d;
    logic            err_q, err_d;

    logic [ARB_MAX_N-1:0] arb_grant_ext;
    logic                 owner_req;
    logic                 wd_expire;

    assign arb_grant_ext = ARB_MAX_N'(arb_grant);

    // The held grant is the owner, so masking req with it selects req[owner]
    assign owner_req = |(req & grant_q);

`ifdef GRANT_TIMEOUT_EN
    grant_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .active_i (state_q == ST_GRANT),
        .xfer_i   (xfer),
        .expire_o (wd_expire)
    );
`else
    assign wd_expire = 1'b0;
`endif

    // Next-state and release decisions; release causes are checked in priority order
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        beat_d   = beat_q;
        done_d   = 1'b0;
        forced_d = 1'b0;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_grant != '0) begin
                    if (is_onehot(arb_grant_ext)) begin
                        grant_d = arb_grant;
                        beat_d  = '0;
                        state_d = ST_GRANT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_GRANT: begin
                if (xfer && last) begin
                    done_d  = 1'b1;
                    grant_d = '0;
                    state_d = ST_RELEASE;
                end else if (xfer && (beat_q == LAST_BEAT)) begin
                    forced_d = 1'b1;
                    grant_d  = '0;
                    state_d  = ST_RELEASE;
                end else if (!xfer && !owner_req) begin
                    forced_d = 1'b1;
                    grant_d  = '0;
                    state_d  = ST_RELEASE;
                end else if (wd_expire) begin
                    forced_d = 1'b1;
                    grant_d  = '0;
                    state_d  = ST_RELEASE;
                end else if (xfer) begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State, held grant, beat counter, completion pulses and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            beat_q   <= '0;
            done_q   <= 1'b0;
            forced_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            beat_q   <= beat_d;
            done_q   <= done_d;
            forced_q <= forced_d;
            err_q    <= err_d;
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q == ST_GRANT);
    assign beat_cnt   = beat_q;
    assign done       = done_q;
    assign forced     = forced_q;
    assign err_onehot = err_q;

endmodule
